// File: rtl/fwd_pkg.sv
// Shared types and defaults for the EX-stage forwarding and
// load-use hazard unit.
package fwd_pkg;

  localparam int unsigned NUM_SRC_DEF    = 2;
  localparam int unsigned ADDR_W_DEF     = 5;
  localparam int unsigned FWD_DEPTH_DEF  = 2;
  localparam int unsigned LOAD_STALL_DEF = 1;
  localparam int unsigned ADDR_MAX       = 16;
  localparam int unsigned CNT_W          = 32;

  // rd is stored zero-extended so the struct is width-agnostic
  typedef struct packed {
    logic [ADDR_MAX-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_t;

  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_sel_prio.sv
// Per-source forwarding select: picks the youngest eligible
// producer among stages 1..FWD_DEPTH, or 0 for the register file.
module fwd_sel_prio
  import fwd_pkg::*;
#(
  parameter int unsigned FWD_DEPTH  = FWD_DEPTH_DEF,
  parameter int unsigned LOAD_STALL = LOAD_STALL_DEF,
  parameter int unsigned SEL_W      = sel_w(FWD_DEPTH_DEF)
) (
  input  stage_t [FWD_DEPTH:1] stg_i,
  input  logic [ADDR_MAX-1:0]  rs_i,
  input  logic                 used_i,
  output logic [SEL_W-1:0]     sel_o
);

  logic found;

  // load data is not yet available in stages 1..LOAD_STALL
  always_comb begin
    sel_o = '0;
    found = 1'b0;
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      if (!found && used_i
          && stg_i[k].regwrite
          && stg_i[k].rd != '0
          && stg_i[k].rd == rs_i
          && !(stg_i[k].memread
               && k <= int'(LOAD_STALL))) begin
        sel_o = SEL_W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Shadow pipeline of EX and later stages driving operand
// forwarding selects, load-use stalls and a stall counter.
module forward_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FWD_DEPTH  = FWD_DEPTH_DEF,
  parameter int unsigned LOAD_STALL = LOAD_STALL_DEF,
  parameter logic [CNT_W-1:0] CNT_RST = '0,
  localparam int unsigned SEL_W     = sel_w(FWD_DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      hold_i,
  input  logic                      flush_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [ADDR_W-1:0]         id_rd_addr_i,
  input  logic                      id_regwrite_i,
  input  logic                      id_memread_i,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o,
  output logic                      stall_o,
  output logic                      bubble_o,
  output logic [CNT_W-1:0]          stall_count_o
);

  stage_t [FWD_DEPTH:0] stg_q, stg_d;

  logic [NUM_SRC-1:0][ADDR_MAX-1:0] rs_q, rs_d, id_rs;
  logic [NUM_SRC-1:0]               used_q, used_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             hazard;

  always_comb begin
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      id_rs[s] = ADDR_MAX'(id_rs_addr_i[s*ADDR_W +: ADDR_W]);
    end
  end

  // load in stages 0..LOAD_STALL-1 cannot feed the ID consumer
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < int'(NUM_SRC); s++) begin
      for (int j = 0; j < int'(LOAD_STALL); j++) begin
        if (id_rs_used_i[s]
            && id_rs[s] != '0
            && stg_q[j].memread
            && stg_q[j].regwrite
            && stg_q[j].rd == id_rs[s]) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall_o  = !flush_i && id_valid_i && hazard;
  assign bubble_o = flush_i || stall_o || !id_valid_i;

  always_comb begin
    stg_d  = stg_q;
    rs_d   = rs_q;
    used_d = used_q;
    cnt_d  = cnt_q;
    if (!hold_i) begin
      for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
        stg_d[k] = stg_q[k-1];
      end
      if (bubble_o) begin
        stg_d[0] = '0;
        rs_d     = '0;
        used_d   = '0;
      end else begin
        stg_d[0].rd       = ADDR_MAX'(id_rd_addr_i);
        stg_d[0].regwrite = id_regwrite_i;
        stg_d[0].memread  = id_memread_i;
        rs_d              = id_rs;
        used_d            = id_rs_used_i;
      end
      if (stall_o && cnt_q != '1) begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_q  <= '0;
      rs_q   <= '0;
      used_q <= '0;
      cnt_q  <= CNT_RST;
    end else begin
      stg_q  <= stg_d;
      rs_q   <= rs_d;
      used_q <= used_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_count_o = cnt_q;

  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_sel
    fwd_sel_prio #(
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_STALL (LOAD_STALL),
      .SEL_W      (SEL_W)
    ) u_sel (
      .stg_i  (stg_q[FWD_DEPTH:1]),
      .rs_i   (rs_q[s]),
      .used_i (used_q[s]),
      .sel_o  (ex_fwd_sel_o[s*SEL_W +: SEL_W])
    );
  end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Directed bench: default config via vector table, plus a
// deep-pipeline config for multi-cycle load stalls.
module tb_forward_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_hold, a_flush, a_valid;
  logic [9:0]  a_rs;
  logic [1:0]  a_used;
  logic [4:0]  a_rd;
  logic        a_rw, a_mr;
  logic [3:0]  a_sel;
  logic        a_stall, a_bub;
  logic [31:0] a_cnt;

  forward_hazard_unit dut_a (
    .clk_i         (clk),
    .rst_i         (a_rst),
    .hold_i        (a_hold),
    .flush_i       (a_flush),
    .id_valid_i    (a_valid),
    .id_rs_addr_i  (a_rs),
    .id_rs_used_i  (a_used),
    .id_rd_addr_i  (a_rd),
    .id_regwrite_i (a_rw),
    .id_memread_i  (a_mr),
    .ex_fwd_sel_o  (a_sel),
    .stall_o       (a_stall),
    .bubble_o      (a_bub),
    .stall_count_o (a_cnt)
  );

  logic        b_rst, b_hold, b_flush, b_valid;
  logic [14:0] b_rs;
  logic [2:0]  b_used;
  logic [4:0]  b_rd;
  logic        b_rw, b_mr;
  logic [8:0]  b_sel;
  logic        b_stall, b_bub;
  logic [31:0] b_cnt;

  forward_hazard_unit #(
    .NUM_SRC    (3),
    .ADDR_W     (5),
    .FWD_DEPTH  (4),
    .LOAD_STALL (2),
    .CNT_RST    (32'hFFFF_FFFE)
  ) dut_b (
    .clk_i         (clk),
    .rst_i         (b_rst),
    .hold_i        (b_hold),
    .flush_i       (b_flush),
    .id_valid_i    (b_valid),
    .id_rs_addr_i  (b_rs),
    .id_rs_used_i  (b_used),
    .id_rd_addr_i  (b_rd),
    .id_regwrite_i (b_rw),
    .id_memread_i  (b_mr),
    .ex_fwd_sel_o  (b_sel),
    .stall_o       (b_stall),
    .bubble_o      (b_bub),
    .stall_count_o (b_cnt)
  );

  typedef struct {
    logic        hold, flush, valid;
    logic [4:0]  rs1, rs2;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        rw, mr;
    logic        stall, bub;
    logic [1:0]  s1, s2;
    logic [31:0] cnt;
  } vec_t;

  vec_t tv[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(
    input logic h, f, v,
    input logic [4:0] r1, r2,
    input logic [1:0] u,
    input logic [4:0] d,
    input logic w, m, st, bb,
    input logic [1:0] e1, e2,
    input logic [31:0] c
  );
    vec_t t;
    t.hold = h; t.flush = f; t.valid = v;
    t.rs1 = r1; t.rs2 = r2; t.used = u;
    t.rd = d; t.rw = w; t.mr = m;
    t.stall = st; t.bub = bb;
    t.s1 = e1; t.s2 = e2; t.cnt = c;
    tv.push_back(t);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic a_drive(
    input logic h, f, v,
    input logic [4:0] r1, r2,
    input logic [1:0] u,
    input logic [4:0] d,
    input logic w, m
  );
    a_hold = h; a_flush = f; a_valid = v;
    a_rs = {r2, r1}; a_used = u;
    a_rd = d; a_rw = w; a_mr = m;
  endtask

  task automatic b_drive(
    input logic v,
    input logic [4:0] r0, r1, r2,
    input logic [2:0] u,
    input logic [4:0] d,
    input logic w, m
  );
    b_hold = 1'b0; b_flush = 1'b0; b_valid = v;
    b_rs = {r2, r1, r0}; b_used = u;
    b_rd = d; b_rw = w; b_mr = m;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    b_drive(0, 0, 0, 0, 3'b000, 0, 0, 0);

    // h f v rs1 rs2 used rd rw mr | stall bub s1 s2 cnt
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,0,0,0);
    add(0,0,1, 1,2,2'b11, 5,1,0,  0,0,0,0,0);
    add(0,0,1, 5,3,2'b11, 6,1,0,  0,0,0,0,0);
    add(0,0,1, 4,5,2'b11, 8,1,0,  0,0,1,0,0);
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,0,2,0);
    add(0,0,1, 0,0,2'b00, 5,1,0,  0,0,0,0,0);
    add(0,0,1, 0,0,2'b00, 5,1,0,  0,0,0,0,0);
    add(0,0,1, 5,5,2'b11, 9,1,0,  0,0,0,0,0);
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,1,1,0);
    add(0,0,1, 1,0,2'b01, 7,1,1,  0,0,0,0,0);
    add(0,0,1, 7,7,2'b11, 8,1,0,  1,1,0,0,0);
    add(0,0,1, 7,7,2'b11, 8,1,0,  0,0,0,0,1);
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,2,2,1);
    add(0,0,1, 1,0,2'b01, 7,1,1,  0,0,0,0,1);
    add(0,1,1, 7,7,2'b11, 8,1,0,  0,1,0,0,1);
    add(0,0,1, 0,0,2'b00, 0,1,0,  0,0,0,0,1);
    add(0,0,1, 0,0,2'b11, 9,1,0,  0,0,0,0,1);
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,0,0,1);
    add(0,0,1, 0,0,2'b00, 0,1,1,  0,0,0,0,1);
    add(0,0,1, 0,0,2'b11,10,1,0,  0,0,0,0,1);
    add(0,0,1, 0,0,2'b00, 7,1,1,  0,0,0,0,1);
    add(1,0,1, 7,2,2'b11, 8,1,0,  1,1,0,0,1);
    add(1,0,1, 7,2,2'b11, 8,1,0,  1,1,0,0,1);
    add(1,0,1, 7,2,2'b11, 8,1,0,  1,1,0,0,1);
    add(0,0,1, 7,2,2'b11, 8,1,0,  1,1,0,0,1);
    add(0,0,1, 7,2,2'b11, 8,1,0,  0,0,0,0,2);
    add(0,0,0, 0,0,2'b00, 0,0,0,  0,1,2,0,2);

    tick; tick;
    a_rst = 1'b0; b_rst = 1'b0;

    foreach (tv[i]) begin
      a_drive(tv[i].hold, tv[i].flush, tv[i].valid,
              tv[i].rs1, tv[i].rs2, tv[i].used,
              tv[i].rd, tv[i].rw, tv[i].mr);
      @(negedge clk);
      chk($sformatf("v%0d stall", i), 32'(a_stall), 32'(tv[i].stall));
      chk($sformatf("v%0d bubble", i), 32'(a_bub), 32'(tv[i].bub));
      chk($sformatf("v%0d sel0", i), 32'(a_sel[1:0]), 32'(tv[i].s1));
      chk($sformatf("v%0d sel1", i), 32'(a_sel[3:2]), 32'(tv[i].s2));
      chk($sformatf("v%0d cnt", i), a_cnt, tv[i].cnt);
      tick;
    end

    // reset in the middle of a held load-use stall
    a_drive(0, 0, 1, 0, 0, 2'b00, 7, 1, 1);
    tick;
    a_drive(0, 0, 1, 7, 7, 2'b11, 8, 1, 0);
    @(negedge clk);
    chk("rst_mid pre stall", 32'(a_stall), 32'd1);
    a_rst = 1'b1; a_hold = 1'b1;
    tick;
    a_rst = 1'b0; a_hold = 1'b0;
    @(negedge clk);
    chk("rst_mid stall", 32'(a_stall), 32'd0);
    chk("rst_mid bubble", 32'(a_bub), 32'd0);
    chk("rst_mid cnt", a_cnt, 32'd0);
    chk("rst_mid sel", 32'(a_sel), 32'd0);
    tick;
    a_drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    tick;
    @(negedge clk);
    chk("rst_mid sel late", 32'(a_sel), 32'd0);
    chk("rst_mid cnt late", a_cnt, 32'd0);

    // deep config: LW x9 then consumer on src0 and src2
    @(negedge clk);
    chk("b reset cnt", b_cnt, 32'hFFFF_FFFE);
    chk("b reset stall", 32'(b_stall), 32'd0);
    tick;
    b_drive(1, 0, 0, 0, 3'b000, 9, 1, 1);
    @(negedge clk);
    chk("b lw stall", 32'(b_stall), 32'd0);
    tick;
    b_drive(1, 9, 3, 9, 3'b101, 10, 1, 0);
    @(negedge clk);
    chk("b stall1", 32'(b_stall), 32'd1);
    chk("b bubble1", 32'(b_bub), 32'd1);
    chk("b cnt1", b_cnt, 32'hFFFF_FFFE);
    tick;
    @(negedge clk);
    chk("b stall2", 32'(b_stall), 32'd1);
    chk("b cnt2", b_cnt, 32'hFFFF_FFFF);
    tick;
    @(negedge clk);
    chk("b stall3", 32'(b_stall), 32'd0);
    chk("b bubble3", 32'(b_bub), 32'd0);
    chk("b cnt sat", b_cnt, 32'hFFFF_FFFF);
    tick;
    b_drive(0, 0, 0, 0, 3'b000, 0, 0, 0);
    @(negedge clk);
    chk("b sel3", 32'(b_sel), 32'(9'b011_000_011));
    chk("b cnt sat2", b_cnt, 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
